// File: rtl/pc_sequencer_if.sv
// Instruction- and data-memory request/response handshake bundle for the RV32I control sequencer.
// The sequencer is the master: it raises the request valids and consumes the readies and response valids.
interface pc_sequencer_if;
  logic imem_req_valid;
  logic imem_req_ready;
  logic imem_rsp_valid;
  logic dmem_req_valid;
  logic dmem_req_ready;
  logic dmem_rsp_valid;

  // A request valid rises in FETCH/MEM and stays high until the cycle ready is seen.
  // A response valid is a single-cycle strobe that completes the transaction.
  modport master (
    output imem_req_valid,
    input  imem_req_ready,
    input  imem_rsp_valid,
    output dmem_req_valid,
    input  dmem_req_ready,
    input  dmem_rsp_valid
  );

  modport slave (
    input  imem_req_valid,
    output imem_req_ready,
    output imem_rsp_valid,
    input  dmem_req_valid,
    output dmem_req_ready,
    output dmem_rsp_valid
  );
endinterface

// File: rtl/pc_sequencer.sv
// Multi-cycle control FSM for the RV32I core: fetch/decode/execute/memory/writeback sequencing,
// sole owner of the PC enable, with bus-timeout and misaligned-target faults and a retire counter.
module pc_sequencer #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    pc_sequencer_if.master     bus,
    output logic               ir_load,
    input  logic               is_load,
    input  logic               is_store,
    input  logic               writes_rd,
    input  logic               halt_req,
    input  logic               pc_redirect,
    input  logic [1:0]         next_pc_lsb,
    output logic               rf_we,
    output logic               pc_en,
    output logic               halted,
    output logic               fault,
    output logic [1:0]         fault_cause,
    output logic [CNT_W-1:0]   instret,
    output logic [3:0]         state_dbg
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_FWAIT  = 4'd2,
        S_DECODE = 4'd3,
        S_EXEC   = 4'd4,
        S_MEM    = 4'd5,
        S_MWAIT  = 4'd6,
        S_WB     = 4'd7,
        S_HALT   = 4'd8,
        S_FAULT  = 4'd9
    } state_t;

    localparam logic [15:0] TIMEOUT_LIM = 16'(MEM_TIMEOUT);

    localparam logic [1:0] CAUSE_IMEM  = 2'b01;
    localparam logic [1:0] CAUSE_DMEM  = 2'b10;
    localparam logic [1:0] CAUSE_ALIGN = 2'b11;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] wait_cnt;
    logic        wait_expired;
    logic        misaligned;

    assign wait_expired = (wait_cnt == TIMEOUT_LIM);
    assign misaligned   = pc_redirect && (next_pc_lsb != 2'b00);
    assign state_dbg    = state;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; a response in the expiry cycle takes priority over the timeout.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:   if (run) state_nxt = S_FETCH;
            S_FETCH:  if (bus.imem_req_ready) state_nxt = S_FWAIT;
            S_FWAIT: begin
                if (bus.imem_rsp_valid) state_nxt = S_DECODE;
                else if (wait_expired)  state_nxt = S_FAULT;
            end
            S_DECODE: state_nxt = halt_req ? S_HALT : S_EXEC;
            S_EXEC: begin
                if (misaligned)              state_nxt = S_FAULT;
                else if (is_load || is_store) state_nxt = S_MEM;
                else                          state_nxt = S_WB;
            end
            S_MEM:    if (bus.dmem_req_ready) state_nxt = is_load ? S_MWAIT : S_WB;
            S_MWAIT: begin
                if (bus.dmem_rsp_valid) state_nxt = S_WB;
                else if (wait_expired)  state_nxt = S_FAULT;
            end
            S_WB:     state_nxt = run ? S_FETCH : S_IDLE;
            S_HALT:   state_nxt = S_HALT;
            S_FAULT:  state_nxt = S_FAULT;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Output logic, decoded from the registered state plus same-cycle inputs.
    always_comb begin
        bus.imem_req_valid = 1'b0;
        bus.dmem_req_valid = 1'b0;
        ir_load            = 1'b0;
        rf_we              = 1'b0;
        pc_en              = 1'b0;
        halted             = 1'b0;
        fault              = 1'b0;
        unique case (state)
            S_FETCH: bus.imem_req_valid = 1'b1;
            S_FWAIT: ir_load            = bus.imem_rsp_valid;
            S_MEM:   bus.dmem_req_valid = 1'b1;
            S_WB: begin
                pc_en = 1'b1;
                rf_we = writes_rd & ~is_store;
            end
            S_HALT:  halted = 1'b1;
            S_FAULT: fault  = 1'b1;
            default: ;
        endcase
    end

    // Response-wait timer: zero outside the wait states, so it starts from 0 on every entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            wait_cnt <= '0;
        else if (state == S_FWAIT || state == S_MWAIT)
            wait_cnt <= wait_cnt + 16'd1;
        else
            wait_cnt <= '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fault_cause <= 2'b00;
        end else if (state_nxt == S_FAULT && state != S_FAULT) begin
            unique case (state)
                S_FWAIT: fault_cause <= CAUSE_IMEM;
                S_MWAIT: fault_cause <= CAUSE_DMEM;
                default: fault_cause <= CAUSE_ALIGN;
            endcase
        end
    end

    // Retire counter; wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)         instret <= '0;
        else if (pc_en)    instret <= instret + 1'b1;
    end

    a_fetch_hold: assert property (@(posedge clk) disable iff (reset)
        bus.imem_req_valid && !bus.imem_req_ready |=> bus.imem_req_valid);
    a_mem_hold: assert property (@(posedge clk) disable iff (reset)
        bus.dmem_req_valid && !bus.dmem_req_ready |=> bus.dmem_req_valid);
    a_pc_en_pulse: assert property (@(posedge clk) disable iff (reset)
        pc_en |=> !pc_en);
    a_rf_we_in_wb: assert property (@(posedge clk) disable iff (reset)
        rf_we |-> pc_en);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: cycle-by-cycle stimulus with hand-derived expected
// state, strobes, fault status and retire count.
module tb_pc_sequencer;

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_FWAIT  = 4'd2;
  localparam logic [3:0] S_DECODE = 4'd3;
  localparam logic [3:0] S_EXEC   = 4'd4;
  localparam logic [3:0] S_MEM    = 4'd5;
  localparam logic [3:0] S_MWAIT  = 4'd6;
  localparam logic [3:0] S_WB     = 4'd7;
  localparam logic [3:0] S_HALT   = 4'd8;
  localparam logic [3:0] S_FAULT  = 4'd9;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic        ir_load;
  logic        is_load = 1'b0;
  logic        is_store = 1'b0;
  logic        writes_rd = 1'b0;
  logic        halt_req = 1'b0;
  logic        pc_redirect = 1'b0;
  logic [1:0]  next_pc_lsb = 2'b00;
  logic        rf_we;
  logic        pc_en;
  logic        halted;
  logic        fault;
  logic [1:0]  fault_cause;
  logic [31:0] instret;
  logic [3:0]  state_dbg;

  int total = 0;
  int bad = 0;

  pc_sequencer_if bus ();

  pc_sequencer #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .bus         (bus.master),
    .ir_load     (ir_load),
    .is_load     (is_load),
    .is_store    (is_store),
    .writes_rd   (writes_rd),
    .halt_req    (halt_req),
    .pc_redirect (pc_redirect),
    .next_pc_lsb (next_pc_lsb),
    .rf_we       (rf_we),
    .pc_en       (pc_en),
    .halted      (halted),
    .fault       (fault),
    .fault_cause (fault_cause),
    .instret     (instret),
    .state_dbg   (state_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  function automatic logic [31:0] b(input logic x);
    return {31'b0, x};
  endfunction

  function automatic logic [31:0] st(input logic [3:0] s);
    return {28'b0, s};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    run = 1'b0; is_load = 1'b0; is_store = 1'b0; writes_rd = 1'b0;
    halt_req = 1'b0; pc_redirect = 1'b0; next_pc_lsb = 2'b00;
    bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b0;
    bus.dmem_req_ready = 1'b0; bus.dmem_rsp_valid = 1'b0;
  endtask

  // Leaves reset released at a falling edge; the caller's cycle 0 is the current (IDLE) cycle.
  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    @(negedge clk);
    #1;
    chk("rst_state", st(state_dbg), st(S_IDLE));
    chk("rst_pc_en", b(pc_en), 32'd0);
    chk("rst_instret", instret, 32'd0);
    chk("rst_cause", {30'b0, fault_cause}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [3:0] alu_seq [5];
    logic [3:0] t2_seq [16];
    logic [3:0] t4_seq [13];
    logic [3:0] exp_s;
    alu_seq = '{S_FETCH, S_FWAIT, S_DECODE, S_EXEC, S_WB};
    t2_seq  = '{S_IDLE, S_FETCH, S_FWAIT, S_DECODE, S_EXEC, S_MEM, S_MWAIT, S_MWAIT,
                S_WB, S_FETCH, S_FWAIT, S_DECODE, S_EXEC, S_MEM, S_WB, S_IDLE};
    t4_seq  = '{S_IDLE, S_FETCH, S_FWAIT, S_DECODE, S_EXEC, S_WB, S_FETCH, S_FWAIT,
                S_DECODE, S_EXEC, S_FAULT, S_FAULT, S_FAULT};
    clear_inputs();

    // 1: back-to-back ALU ops, zero-wait memory -> one retire every 5 cycles
    do_reset();
    run = 1'b1; writes_rd = 1'b1;
    bus.imem_req_ready = 1'b1; bus.imem_rsp_valid = 1'b1;
    for (int c = 0; c < 21; c++) begin
      if (c != 0) @(negedge clk);
      #1;
      exp_s = (c == 0) ? S_IDLE : alu_seq[(c - 1) % 5];
      chk("t1_state", st(state_dbg), st(exp_s));
      chk("t1_pc_en", b(pc_en), b(c > 0 && c % 5 == 0));
      chk("t1_rf_we", b(rf_we), b(c > 0 && c % 5 == 0));
      chk("t1_ir_load", b(ir_load), b(c % 5 == 2));
      if (c == 20) chk("t1_instret_wb", instret, 32'd3);
    end
    @(negedge clk); #1;
    chk("t1_instret", instret, 32'd4);

    // 2: load with a late response (retire in cycle 8), then a store (no MWAIT, no rf_we)
    do_reset();
    run = 1'b1; writes_rd = 1'b1; is_load = 1'b1;
    bus.imem_req_ready = 1'b1; bus.imem_rsp_valid = 1'b1; bus.dmem_req_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      if (c != 0) @(negedge clk);
      if (c == 9) begin is_load = 1'b0; is_store = 1'b1; end
      if (c == 14) run = 1'b0;
      bus.dmem_rsp_valid = (c == 7);
      #1;
      chk("t2_state", st(state_dbg), st(t2_seq[c]));
      chk("t2_pc_en", b(pc_en), b(c == 8 || c == 14));
      chk("t2_rf_we", b(rf_we), b(c == 8));
      chk("t2_dmem_valid", b(bus.dmem_req_valid), b(c == 5 || c == 13));
    end
    chk("t2_instret", instret, 32'd2);

    // 3: imem never answers -> imem timeout fault once the wait count reaches 4
    do_reset();
    run = 1'b1; bus.imem_req_ready = 1'b1;
    for (int c = 0; c < 11; c++) begin
      if (c != 0) @(negedge clk);
      #1;
      exp_s = (c == 0) ? S_IDLE : (c == 1) ? S_FETCH : (c <= 6) ? S_FWAIT : S_FAULT;
      chk("t3_state", st(state_dbg), st(exp_s));
      chk("t3_fault", b(fault), b(c >= 7));
      chk("t3_cause", {30'b0, fault_cause}, (c >= 7) ? 32'd1 : 32'd0);
      chk("t3_pc_en", b(pc_en), 32'd0);
      chk("t3_imem_valid", b(bus.imem_req_valid), b(c == 1));
    end

    // 3b: stalled request handshake is untimed; a response at the expiry count still wins
    do_reset();
    run = 1'b1; writes_rd = 1'b1;
    for (int c = 0; c < 17; c++) begin
      if (c != 0) @(negedge clk);
      bus.imem_req_ready = (c >= 8);
      bus.imem_rsp_valid = (c == 13);
      #1;
      exp_s = (c == 0) ? S_IDLE : (c <= 8) ? S_FETCH : (c <= 13) ? S_FWAIT :
              (c == 14) ? S_DECODE : (c == 15) ? S_EXEC : S_WB;
      chk("t3b_state", st(state_dbg), st(exp_s));
      chk("t3b_imem_valid", b(bus.imem_req_valid), b(c >= 1 && c <= 8));
      chk("t3b_ir_load", b(ir_load), b(c == 13));
      chk("t3b_fault", b(fault), 32'd0);
      chk("t3b_pc_en", b(pc_en), b(c == 16));
    end

    // 4: aligned redirect retires; a redirect to lsb=10 faults after EXEC with instret unchanged
    do_reset();
    run = 1'b1; writes_rd = 1'b1; pc_redirect = 1'b1; next_pc_lsb = 2'b00;
    bus.imem_req_ready = 1'b1; bus.imem_rsp_valid = 1'b1;
    for (int c = 0; c < 13; c++) begin
      if (c != 0) @(negedge clk);
      if (c == 6) next_pc_lsb = 2'b10;
      #1;
      chk("t4_state", st(state_dbg), st(t4_seq[c]));
      chk("t4_pc_en", b(pc_en), b(c == 5));
      chk("t4_fault", b(fault), b(c >= 10));
      chk("t4_cause", {30'b0, fault_cause}, (c >= 10) ? 32'd3 : 32'd0);
      chk("t4_instret", instret, (c >= 6) ? 32'd1 : 32'd0);
    end

    // 5: halt_req in DECODE -> sticky HALT regardless of run toggling
    do_reset();
    run = 1'b1; halt_req = 1'b1;
    bus.imem_req_ready = 1'b1; bus.imem_rsp_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (c != 0) @(negedge clk);
      run = (c < 5) || (c % 2 == 1);
      #1;
      exp_s = (c == 0) ? S_IDLE : (c == 1) ? S_FETCH : (c == 2) ? S_FWAIT :
              (c == 3) ? S_DECODE : S_HALT;
      chk("t5_state", st(state_dbg), st(exp_s));
      chk("t5_halted", b(halted), b(c >= 4));
      chk("t5_pc_en", b(pc_en), 32'd0);
      chk("t5_imem_valid", b(bus.imem_req_valid), b(c == 1));
      chk("t5_instret", instret, 32'd0);
    end

    // 6: reset while waiting in MWAIT abandons the load; a fresh ALU op then retires normally
    do_reset();
    run = 1'b1; writes_rd = 1'b1; is_load = 1'b1;
    bus.imem_req_ready = 1'b1; bus.imem_rsp_valid = 1'b1; bus.dmem_req_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (c != 0) @(negedge clk);
      #1;
    end
    chk("t6_pre_state", st(state_dbg), st(S_MWAIT));
    @(negedge clk);
    reset = 1'b1;
    bus.dmem_rsp_valid = 1'b1;
    #1;
    chk("t6_rst_state", st(state_dbg), st(S_IDLE));
    chk("t6_rst_pc_en", b(pc_en), 32'd0);
    chk("t6_rst_rf_we", b(rf_we), 32'd0);
    chk("t6_rst_dmem_valid", b(bus.dmem_req_valid), 32'd0);
    chk("t6_rst_imem_valid", b(bus.imem_req_valid), 32'd0);
    chk("t6_rst_instret", instret, 32'd0);
    @(negedge clk);
    reset = 1'b0; is_load = 1'b0; bus.dmem_rsp_valid = 1'b0;
    for (int d = 0; d < 7; d++) begin
      if (d != 0) @(negedge clk);
      #1;
      exp_s = (d == 0) ? S_IDLE : (d == 6) ? S_FETCH : alu_seq[d - 1];
      chk("t6_state", st(state_dbg), st(exp_s));
      chk("t6_pc_en", b(pc_en), b(d == 5));
      chk("t6_imem_valid", b(bus.imem_req_valid), b(d == 1 || d == 6));
      chk("t6_instret", instret, (d == 6) ? 32'd1 : 32'd0);
    end

    // Final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
